// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access pipeline stage.
//   - Bus widths between execute, memory, write-back and decode.
//   - Load operation encodings carried in the execute-to-memory bus.
//   - Packed view of the execute-to-memory bus.
//   - Response-buffer state encoding.
package mem_stage_pkg;

  localparam int ES_TO_MS_BUS_WD = 74;
  localparam int MS_TO_WS_BUS_WD = 70;
  localparam int MS_TO_DS_BUS_WD = 38;

  // Encodings 3'b101..3'b111 are not listed and behave as a full word load.
  typedef enum logic [2:0] {
    LD_W  = 3'b000,
    LD_B  = 3'b001,
    LD_H  = 3'b010,
    LD_BU = 3'b011,
    LD_HU = 3'b100
  } load_op_e;

  typedef struct packed {
    logic [2:0]  load_op;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] alu_result;
    logic [31:0] pc;
  } es_to_ms_t;

  typedef enum logic {
    BUF_EMPTY = 1'b0,
    BUF_FULL  = 1'b1
  } buf_state_e;

endpackage

// File: rtl/mem_load_ext.sv
// Load data extraction: selects the byte, half or word addressed by the low
// address bits from the 32-bit memory word and sign/zero-extends it.
// Ports:
//   load_op   in  3   load operation encoding
//   a         in  2   low two bits of the load address
//   mem_word  in  32  aligned word returned by the data SRAM
//   result    out 32  extended load value
module mem_load_ext
  import mem_stage_pkg::*;
(
  input  logic [2:0]  load_op,
  input  logic [1:0]  a,
  input  logic [31:0] mem_word,
  output logic [31:0] result
);

  logic [7:0]  byte_val;
  logic [15:0] half_val;

  // Halfword selection ignores a[0]; alignment is not checked here.
  assign byte_val = mem_word[{a, 3'b000} +: 8];
  assign half_val = a[1] ? mem_word[31:16] : mem_word[15:0];

  always_comb begin
    unique case (load_op)
      LD_B:    result = {{24{byte_val[7]}}, byte_val};
      LD_H:    result = {{16{half_val[15]}}, half_val};
      LD_BU:   result = {24'h0, byte_val};
      LD_HU:   result = {16'h0, half_val};
      default: result = mem_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage (between execute and write-back).
// Holds one instruction; a load waits for the data-SRAM response, which is
// parked in a one-entry buffer if write-back is stalled when it arrives.
// Ports:
//   clk, reset          clock; synchronous active-high reset
//   ws_allowin          in   write-back can accept an instruction
//   ms_allowin          out  this stage can accept an instruction
//   es_to_ms_valid/bus  in   instruction offered by execute (74 bits)
//   ms_to_ws_valid/bus  out  completed instruction to write-back (70 bits)
//   ms_to_ds_bus        out  forwarding/hazard info to decode (38 bits)
//   data_sram_data_ok   in   load response valid this cycle
//   data_sram_rdata     in   load response data
module mem_stage
  import mem_stage_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       ws_allowin,
  output logic                       ms_allowin,
  input  logic                       es_to_ms_valid,
  input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
  output logic                       ms_to_ws_valid,
  output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
  output logic [MS_TO_DS_BUS_WD-1:0] ms_to_ds_bus,
  input  logic                       data_sram_data_ok,
  input  logic [31:0]                data_sram_rdata
);

  es_to_ms_t   ms_r;
  logic        ms_valid;
  logic        ms_ready_go;
  buf_state_e  buf_state, buf_state_nxt;
  logic        buf_valid;
  logic        buf_capture;
  logic [31:0] rdata_buf;
  logic [31:0] mem_word;
  logic [31:0] load_result;
  logic [31:0] final_result;
  logic        load_wait;
  logic [4:0]  ds_dest;

  // ---------------- handshake ----------------
  assign buf_valid      = (buf_state == BUF_FULL);
  assign ms_ready_go    = !ms_r.res_from_mem || data_sram_data_ok || buf_valid;
  assign ms_allowin     = !ms_valid || (ms_ready_go && ws_allowin);
  assign ms_to_ws_valid = ms_valid && ms_ready_go;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      ms_valid <= 1'b0;
    end else if (ms_allowin) begin
      ms_valid <= es_to_ms_valid;
    end
  end

  // NOTE: the payload register carries no reset; it is only meaningful while
  // ms_valid is set, and skipping the reset keeps it a plain enabled flop.
  always_ff @(posedge clk) begin
    if (es_to_ms_valid && ms_allowin) begin
      ms_r <= es_to_ms_bus;
    end
  end

  // ---------------- response buffer ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      buf_state <= BUF_EMPTY;
    end else begin
      buf_state <= buf_state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    buf_state_nxt = buf_state;
    buf_capture   = 1'b0;
    unique case (buf_state)
      BUF_EMPTY: begin
        // Response arrived but write-back cannot take the instruction yet.
        if (ms_valid && ms_r.res_from_mem && data_sram_data_ok && !ws_allowin) begin
          buf_state_nxt = BUF_FULL;
          buf_capture   = 1'b1;
        end
      end
      BUF_FULL: begin
        // ms_ready_go is 1 here, so ws_allowin means the instruction leaves.
        if (ws_allowin) begin
          buf_state_nxt = BUF_EMPTY;
        end
      end
      default: buf_state_nxt = BUF_EMPTY;
    endcase
  end

  always_ff @(posedge clk) begin
    if (buf_capture) begin
      rdata_buf <= data_sram_rdata;
    end
  end

  // ---------------- load extraction and result ----------------
  assign mem_word = buf_valid ? rdata_buf : data_sram_rdata;

  mem_load_ext u_load_ext (
    .load_op  (ms_r.load_op),
    .a        (ms_r.alu_result[1:0]),
    .mem_word (mem_word),
    .result   (load_result)
  );

  assign final_result = ms_r.res_from_mem ? load_result : ms_r.alu_result;

  assign ms_to_ws_bus = {ms_r.gr_we, ms_r.dest, final_result, ms_r.pc};

  // ---------------- decode forwarding / hazard ----------------
  assign ds_dest      = (ms_valid && ms_r.gr_we) ? ms_r.dest : 5'd0;
  assign load_wait    = ms_valid && ms_r.res_from_mem && !ms_ready_go;
  assign ms_to_ds_bus = {load_wait, ds_dest, final_result};

endmodule
